// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: opcodes, ALUOp codes,
// state encoding and datapath mux selects. Optional memory wait: MC_MEM_WAIT_EN.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_JR    = 6'h08;

    localparam logic [2:0] ALUOP_LUI = 3'b000;
    localparam logic [2:0] ALUOP_SUB = 3'b001;
    localparam logic [2:0] ALUOP_ADD = 3'b100;
    localparam logic [2:0] ALUOP_OR  = 3'b101;
    localparam logic [2:0] ALUOP_AND = 3'b110;
    localparam logic [2:0] ALUOP_R   = 3'b111;

    localparam logic [1:0] REGDST_RT   = 2'b00;
    localparam logic [1:0] REGDST_RD   = 2'b01;
    localparam logic [1:0] REGDST_RA   = 2'b10;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_RS     = 2'b11;

    typedef enum logic [3:0] {
        ST_RST      = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_MEM_ADDR = 4'd3,
        ST_MEM_RD   = 4'd4,
        ST_MEM_WB   = 4'd5,
        ST_MEM_WR   = 4'd6,
        ST_EXEC_R   = 4'd7,
        ST_EXEC_I   = 4'd8,
        ST_R_WB     = 4'd9,
        ST_I_WB     = 4'd10,
        ST_BRANCH   = 4'd11,
        ST_JUMP     = 4'd12,
        ST_JAL_LINK = 4'd13,
        ST_JR       = 4'd14
    } mc_state_t;

    function automatic logic is_decoded(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE,
            OP_ADDI, OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW: is_decoded = 1'b1;
            default:                                          is_decoded = 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
        case (op)
            OP_ORI:  imm_alu_op = ALUOP_OR;
            OP_ANDI: imm_alu_op = ALUOP_AND;
            OP_LUI:  imm_alu_op = ALUOP_LUI;
            default: imm_alu_op = ALUOP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Combinational Moore decode of FSM state (plus opcode where needed) to every
// datapath control strobe. MC_MEM_WAIT_EN gates the FETCH PC/IR writes on mem_ready.
module mc_output_decode
    import mips_ctrl_pkg::*;
(
    input  mc_state_t   state,
    input  logic [5:0]  opcode,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        PCWriteCondEQ,
    output logic        PCWriteCondNE,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        MemtoReg,
    output logic [1:0]  RegDst,
    output logic        LinkSel,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [2:0]  ALUOp,
    output logic [1:0]  PCSource,
    output logic        illegal_op
);

`ifndef MC_MEM_WAIT_EN
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
`endif

    always_comb begin
        PCWrite       = 1'b0;
        PCWriteCondEQ = 1'b0;
        PCWriteCondNE = 1'b0;
        IorD          = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        RegWrite      = 1'b0;
        MemtoReg      = 1'b0;
        RegDst        = REGDST_RT;
        LinkSel       = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = SRCB_RT;
        ALUOp         = ALUOP_LUI;
        PCSource      = PCSRC_ALU;
        illegal_op    = 1'b0;
        case (state)
            ST_FETCH: begin
                MemRead  = 1'b1;
                ALUSrcB  = SRCB_FOUR;
                ALUOp    = ALUOP_ADD;
`ifdef MC_MEM_WAIT_EN
                // PC and IR load only on the completing cycle so PC+4 happens once
                PCWrite  = mem_ready;
                IRWrite  = mem_ready;
`else
                PCWrite  = 1'b1;
                IRWrite  = 1'b1;
`endif
            end
            ST_DECODE: begin
                ALUSrcB    = SRCB_IMM_SH;
                ALUOp      = ALUOP_ADD;
                illegal_op = ~is_decoded(opcode);
            end
            ST_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALUOP_ADD;
            end
            ST_MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            ST_MEM_WB: begin
                RegWrite = 1'b1;
                RegDst   = REGDST_RT;
                MemtoReg = 1'b1;
            end
            ST_MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            ST_EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_RT;
                ALUOp   = ALUOP_R;
            end
            ST_EXEC_I: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = imm_alu_op(opcode);
            end
            ST_R_WB: begin
                RegWrite = 1'b1;
                RegDst   = REGDST_RD;
            end
            ST_I_WB: begin
                RegWrite = 1'b1;
                RegDst   = REGDST_RT;
            end
            ST_BRANCH: begin
                ALUSrcA       = 1'b1;
                ALUSrcB       = SRCB_RT;
                ALUOp         = ALUOP_SUB;
                PCSource      = PCSRC_ALUOUT;
                PCWriteCondEQ = (opcode == OP_BEQ);
                PCWriteCondNE = (opcode == OP_BNE);
            end
            ST_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = PCSRC_JUMP;
            end
            ST_JAL_LINK: begin
                RegWrite = 1'b1;
                RegDst   = REGDST_RA;
                LinkSel  = 1'b1;
                PCWrite  = 1'b1;
                PCSource = PCSRC_JUMP;
            end
            ST_JR: begin
                PCWrite  = 1'b1;
                PCSource = PCSRC_RS;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS sequencing FSM: state register and next-state logic; outputs
// come from mc_output_decode. MC_MEM_WAIT_EN holds memory states until mem_ready.
module multicycle_control
    import mips_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        PCWriteCondEQ,
    output logic        PCWriteCondNE,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        MemtoReg,
    output logic [1:0]  RegDst,
    output logic        LinkSel,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [2:0]  ALUOp,
    output logic [1:0]  PCSource,
    output logic        illegal_op,
    output logic [3:0]  state
);

    mc_state_t state_q, state_d;
    logic      is_store_q;
    logic      mem_done;

`ifdef MC_MEM_WAIT_EN
    assign mem_done = mem_ready;
`else
    assign mem_done = 1'b1;
`endif

    // LW/SW choice is latched in DECODE so MEM_ADDR ignores later opcode changes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_RST;
            is_store_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_DECODE)
                is_store_q <= (opcode == OP_SW);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RST:      state_d = ST_FETCH;
            ST_FETCH:    state_d = mem_done ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:                      state_d = ST_MEM_ADDR;
                    OP_RTYPE:                          state_d = (funct == FN_JR) ? ST_JR : ST_EXEC_R;
                    OP_ADDI, OP_ORI, OP_ANDI, OP_LUI:  state_d = ST_EXEC_I;
                    OP_BEQ, OP_BNE:                    state_d = ST_BRANCH;
                    OP_J:                              state_d = ST_JUMP;
                    OP_JAL:                            state_d = ST_JAL_LINK;
                    default:                           state_d = ST_FETCH;
                endcase
            end
            ST_MEM_ADDR: state_d = is_store_q ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD:   state_d = mem_done ? ST_MEM_WB : ST_MEM_RD;
            ST_MEM_WR:   state_d = mem_done ? ST_FETCH  : ST_MEM_WR;
            ST_EXEC_R:   state_d = ST_R_WB;
            ST_EXEC_I:   state_d = ST_I_WB;
            ST_MEM_WB, ST_R_WB, ST_I_WB, ST_BRANCH,
            ST_JUMP, ST_JAL_LINK, ST_JR: state_d = ST_FETCH;
            default:     state_d = ST_RST;
        endcase
    end

    assign state = state_q;

    mc_output_decode u_decode (
        .state         (state_q),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .PCWrite       (PCWrite),
        .PCWriteCondEQ (PCWriteCondEQ),
        .PCWriteCondNE (PCWriteCondNE),
        .IorD          (IorD),
        .MemRead       (MemRead),
        .MemWrite      (MemWrite),
        .IRWrite       (IRWrite),
        .RegWrite      (RegWrite),
        .MemtoReg      (MemtoReg),
        .RegDst        (RegDst),
        .LinkSel       (LinkSel),
        .ALUSrcA       (ALUSrcA),
        .ALUSrcB       (ALUSrcB),
        .ALUOp         (ALUOp),
        .PCSource      (PCSource),
        .illegal_op    (illegal_op)
    );

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-instruction state/strobe sequences,
// reset behaviour and, when MC_MEM_WAIT_EN is defined, memory wait holding.
module tb_multicycle_control;

    logic        clk;
    logic        reset;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        mem_ready;
    logic        PCWrite, PCWriteCondEQ, PCWriteCondNE, IorD, MemRead, MemWrite;
    logic        IRWrite, RegWrite, MemtoReg, LinkSel, ALUSrcA, illegal_op;
    logic [1:0]  RegDst, ALUSrcB, PCSource;
    logic [2:0]  ALUOp;
    logic [3:0]  state;

    int checks = 0;
    int errors = 0;

    multicycle_control dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .funct         (funct),
        .mem_ready     (mem_ready),
        .PCWrite       (PCWrite),
        .PCWriteCondEQ (PCWriteCondEQ),
        .PCWriteCondNE (PCWriteCondNE),
        .IorD          (IorD),
        .MemRead       (MemRead),
        .MemWrite      (MemWrite),
        .IRWrite       (IRWrite),
        .RegWrite      (RegWrite),
        .MemtoReg      (MemtoReg),
        .RegDst        (RegDst),
        .LinkSel       (LinkSel),
        .ALUSrcA       (ALUSrcA),
        .ALUSrcB       (ALUSrcB),
        .ALUOp         (ALUOp),
        .PCSource      (PCSource),
        .illegal_op    (illegal_op),
        .state         (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {PCWrite,CondEQ,CondNE,IorD,MemRead,MemWrite,IRWrite,RegWrite,MemtoReg,
    //  RegDst[2],LinkSel,ALUSrcA,ALUSrcB[2],ALUOp[3],PCSource[2],illegal_op}
    logic [20:0] ctl;
    assign ctl = {PCWrite, PCWriteCondEQ, PCWriteCondNE, IorD, MemRead, MemWrite,
                  IRWrite, RegWrite, MemtoReg, RegDst, LinkSel, ALUSrcA, ALUSrcB,
                  ALUOp, PCSource, illegal_op};

    localparam logic [3:0] S_RST = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2,
        S_MEM_ADDR = 4'd3, S_MEM_RD = 4'd4, S_MEM_WB = 4'd5, S_MEM_WR = 4'd6,
        S_EXEC_R = 4'd7, S_EXEC_I = 4'd8, S_R_WB = 4'd9, S_I_WB = 4'd10,
        S_BRANCH = 4'd11, S_JUMP = 4'd12, S_JAL = 4'd13, S_JR = 4'd14;

    localparam logic [20:0] E_ZERO     = 21'd0;
    localparam logic [20:0] E_FETCH    = {1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,2'b00,1'b0,1'b0,2'b01,3'b100,2'b00,1'b0};
    localparam logic [20:0] E_FETCH_WT = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,2'b01,3'b100,2'b00,1'b0};
    localparam logic [20:0] E_DECODE   = {9'b0,2'b00,1'b0,1'b0,2'b11,3'b100,2'b00,1'b0};
    localparam logic [20:0] E_DEC_ILL  = {9'b0,2'b00,1'b0,1'b0,2'b11,3'b100,2'b00,1'b1};
    localparam logic [20:0] E_MEM_ADDR = {9'b0,2'b00,1'b0,1'b1,2'b10,3'b100,2'b00,1'b0};
    localparam logic [20:0] E_MEM_RD   = {1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,12'b0};
    localparam logic [20:0] E_MEM_WB   = {7'b0,1'b1,1'b1,12'b0};
    localparam logic [20:0] E_MEM_WR   = {3'b0,1'b1,1'b0,1'b1,3'b0,12'b0};
    localparam logic [20:0] E_EXEC_R   = {9'b0,2'b00,1'b0,1'b1,2'b00,3'b111,2'b00,1'b0};
    localparam logic [20:0] E_R_WB     = {7'b0,1'b1,1'b0,2'b01,10'b0};
    localparam logic [20:0] E_I_WB     = {7'b0,1'b1,1'b0,2'b00,10'b0};
    localparam logic [20:0] E_BEQ      = {1'b0,1'b1,1'b0,6'b0,2'b00,1'b0,1'b1,2'b00,3'b001,2'b01,1'b0};
    localparam logic [20:0] E_BNE      = {1'b0,1'b0,1'b1,6'b0,2'b00,1'b0,1'b1,2'b00,3'b001,2'b01,1'b0};
    localparam logic [20:0] E_JUMP     = {1'b1,8'b0,2'b00,1'b0,1'b0,2'b00,3'b000,2'b10,1'b0};
    localparam logic [20:0] E_JAL      = {1'b1,6'b0,1'b1,1'b0,2'b10,1'b1,1'b0,2'b00,3'b000,2'b10,1'b0};
    localparam logic [20:0] E_JR       = {1'b1,8'b0,2'b00,1'b0,1'b0,2'b00,3'b000,2'b11,1'b0};

    function automatic logic [20:0] e_exec_i(input logic [2:0] aop);
        return {9'b0,2'b00,1'b0,1'b1,2'b10,aop,2'b00,1'b0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (state !== S_RST || ctl !== E_ZERO) begin
            errors++;
            $display("FAIL reset_hold: state=%0d ctl=%h, expected state=%0d ctl=%h", state, ctl, S_RST, E_ZERO);
        end
        @(negedge clk);
        reset = 1'b1;
        step();
        checks++;
        if (state !== S_FETCH || ctl !== E_FETCH) begin
            errors++;
            $display("FAIL reset_release: state=%0d ctl=%h, expected state=%0d ctl=%h", state, ctl, S_FETCH, E_FETCH);
        end
    endtask

    task automatic test_load_store();
        logic [3:0]  st[5];
        logic [20:0] ev[5];
        opcode = 6'h23; funct = 6'h15;
        st = '{S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_FETCH};
        ev = '{E_DECODE, E_MEM_ADDR, E_MEM_RD, E_MEM_WB, E_FETCH};
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (state !== st[i] || ctl !== ev[i]) begin
                errors++;
                $display("FAIL lw step %0d: state=%0d ctl=%h, expected state=%0d ctl=%h", i, state, ctl, st[i], ev[i]);
            end
        end
        opcode = 6'h2b;
        st = '{S_DECODE, S_MEM_ADDR, S_MEM_WR, S_FETCH, S_FETCH};
        ev = '{E_DECODE, E_MEM_ADDR, E_MEM_WR, E_FETCH, E_FETCH};
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (state !== st[i] || ctl !== ev[i]) begin
                errors++;
                $display("FAIL sw step %0d: state=%0d ctl=%h, expected state=%0d ctl=%h", i, state, ctl, st[i], ev[i]);
            end
        end
    endtask

    task automatic test_alu_ops();
        logic [5:0] ops[4];
        logic [2:0] aops[4];
        logic [3:0]  st[4];
        logic [20:0] ev[4];
        opcode = 6'h00; funct = 6'h20;
        st = '{S_DECODE, S_EXEC_R, S_R_WB, S_FETCH};
        ev = '{E_DECODE, E_EXEC_R, E_R_WB, E_FETCH};
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (state !== st[i] || ctl !== ev[i]) begin
                errors++;
                $display("FAIL rtype step %0d: state=%0d ctl=%h, expected state=%0d ctl=%h", i, state, ctl, st[i], ev[i]);
            end
        end
        ops  = '{6'h08, 6'h0d, 6'h0c, 6'h0f};
        aops = '{3'b100, 3'b101, 3'b110, 3'b000};
        for (int k = 0; k < 4; k++) begin
            opcode = ops[k];
            st = '{S_DECODE, S_EXEC_I, S_I_WB, S_FETCH};
            ev = '{E_DECODE, e_exec_i(aops[k]), E_I_WB, E_FETCH};
            for (int i = 0; i < 4; i++) begin
                step();
                checks++;
                if (state !== st[i] || ctl !== ev[i]) begin
                    errors++;
                    $display("FAIL itype op=%h step %0d: state=%0d ctl=%h, expected state=%0d ctl=%h", ops[k], i, state, ctl, st[i], ev[i]);
                end
            end
        end
    endtask

    task automatic test_control_flow();
        logic [5:0]  ops[5];
        logic [5:0]  fns[5];
        logic [3:0]  mid_st[5];
        logic [20:0] mid_ev[5];
        logic [3:0]  st[3];
        logic [20:0] ev[3];
        ops    = '{6'h04, 6'h05, 6'h02, 6'h03, 6'h00};
        fns    = '{6'h08, 6'h00, 6'h08, 6'h08, 6'h08};
        mid_st = '{S_BRANCH, S_BRANCH, S_JUMP, S_JAL, S_JR};
        mid_ev = '{E_BEQ, E_BNE, E_JUMP, E_JAL, E_JR};
        for (int k = 0; k < 5; k++) begin
            opcode = ops[k]; funct = fns[k];
            st = '{S_DECODE, mid_st[k], S_FETCH};
            ev = '{E_DECODE, mid_ev[k], E_FETCH};
            for (int i = 0; i < 3; i++) begin
                step();
                checks++;
                if (state !== st[i] || ctl !== ev[i]) begin
                    errors++;
                    $display("FAIL flow op=%h step %0d: state=%0d ctl=%h, expected state=%0d ctl=%h", ops[k], i, state, ctl, st[i], ev[i]);
                end
            end
        end
    endtask

    task automatic test_illegal();
        logic [5:0] ops[2];
        ops = '{6'h3f, 6'h01};
        for (int k = 0; k < 2; k++) begin
            opcode = ops[k];
            step();
            checks++;
            if (state !== S_DECODE || ctl !== E_DEC_ILL) begin
                errors++;
                $display("FAIL illegal_decode op=%h: state=%0d ctl=%h, expected state=%0d ctl=%h", ops[k], state, ctl, S_DECODE, E_DEC_ILL);
            end
            step();
            checks++;
            if (state !== S_FETCH || ctl !== E_FETCH) begin
                errors++;
                $display("FAIL illegal_next op=%h: state=%0d ctl=%h, expected state=%0d ctl=%h", ops[k], state, ctl, S_FETCH, E_FETCH);
            end
        end
    endtask

    task automatic test_opcode_hold();
        opcode = 6'h23;
        step();
        step();
        opcode = 6'h2b; funct = 6'h08;
        step();
        checks++;
        if (state !== S_MEM_RD || ctl !== E_MEM_RD) begin
            errors++;
            $display("FAIL opcode_hold: state=%0d ctl=%h, expected state=%0d ctl=%h", state, ctl, S_MEM_RD, E_MEM_RD);
        end
        step();
        step();
        checks++;
        if (state !== S_FETCH) begin
            errors++;
            $display("FAIL opcode_hold_end: state=%0d, expected state=%0d", state, S_FETCH);
        end
    endtask

    task automatic test_reset_mid();
        opcode = 6'h23;
        step();
        step();
        step();
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (state !== S_RST || ctl !== E_ZERO) begin
            errors++;
            $display("FAIL reset_mid: state=%0d ctl=%h, expected state=%0d ctl=%h", state, ctl, S_RST, E_ZERO);
        end
        @(negedge clk);
        reset = 1'b1;
        step();
        checks++;
        if (state !== S_FETCH || ctl !== E_FETCH) begin
            errors++;
            $display("FAIL reset_mid_restart: state=%0d ctl=%h, expected state=%0d ctl=%h", state, ctl, S_FETCH, E_FETCH);
        end
    endtask

`ifdef MC_MEM_WAIT_EN
    task automatic test_mem_wait();
        mem_ready = 1'b0;
        #1;
        checks++;
        if (state !== S_FETCH || ctl !== E_FETCH_WT) begin
            errors++;
            $display("FAIL fetch_wait: state=%0d ctl=%h, expected state=%0d ctl=%h", state, ctl, S_FETCH, E_FETCH_WT);
        end
        step();
        checks++;
        if (state !== S_FETCH || ctl !== E_FETCH_WT) begin
            errors++;
            $display("FAIL fetch_held: state=%0d ctl=%h, expected state=%0d ctl=%h", state, ctl, S_FETCH, E_FETCH_WT);
        end
        mem_ready = 1'b1;
        opcode = 6'h23;
        step();
        step();
        step();
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            checks++;
            if (state !== S_MEM_RD || ctl !== E_MEM_RD) begin
                errors++;
                $display("FAIL mem_rd_hold cycle %0d: state=%0d ctl=%h, expected state=%0d ctl=%h", i, state, ctl, S_MEM_RD, E_MEM_RD);
            end
        end
        mem_ready = 1'b1;
        step();
        checks++;
        if (state !== S_MEM_WB || ctl !== E_MEM_WB) begin
            errors++;
            $display("FAIL mem_rd_release: state=%0d ctl=%h, expected state=%0d ctl=%h", state, ctl, S_MEM_WB, E_MEM_WB);
        end
        step();
        opcode = 6'h2b;
        step();
        step();
        mem_ready = 1'b0;
        step();
        step();
        checks++;
        if (state !== S_MEM_WR || ctl !== E_MEM_WR) begin
            errors++;
            $display("FAIL mem_wr_hold: state=%0d ctl=%h, expected state=%0d ctl=%h", state, ctl, S_MEM_WR, E_MEM_WR);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (state !== S_RST || ctl !== E_ZERO) begin
            errors++;
            $display("FAIL reset_mid_wait: state=%0d ctl=%h, expected state=%0d ctl=%h", state, ctl, S_RST, E_ZERO);
        end
        mem_ready = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        step();
    endtask
`endif

    initial begin
        reset     = 1'b0;
        opcode    = 6'h00;
        funct     = 6'h00;
        mem_ready = 1'b1;
        test_reset();
        test_load_store();
        test_alu_ops();
        test_control_flow();
        test_illegal();
        test_opcode_hold();
        test_reset_mid();
`ifdef MC_MEM_WAIT_EN
        test_mem_wait();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
